divider_seq: RTL and testbench

Parametrised iterative divider producing one quotient bit per cycle with a non-restoring add/subtract datapath. It is the general-width successor of the lab2 32-bit sign-magnitude divider and adds an unsigned mode, a done pulse, divide-by-zero detection and a defined abort-on-reset. It sits beside the ALU as a multi-cycle functional unit under `start`/`busy` control.

---
 rtl/divider_pkg.sv | 16 +
 rtl/div_step.sv | 22 ++
 rtl/divider_seq.sv | 140 ++++++++++++++
 tb/tb_divider_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared FSM encoding, mode constants and width helper for the iterative divider.
package divider_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam bit ModeUnsigned = 1'b0;
  localparam bit ModeSignMag  = 1'b1;

  // Sign-magnitude operands give up their MSB to the sign.
  function automatic int unsigned mag_width(int unsigned width, bit sign_mag);
    return (sign_mag == ModeUnsigned) ? width : width - 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring iteration: shift the partial remainder left, then add or
// subtract the aligned divisor depending on the current sign.
module div_step #(
  parameter int unsigned MagWidth = 31
) (
  input  logic [2*MagWidth:0] pr,
  input  logic [2*MagWidth:0] dv,
  output logic [2*MagWidth:0] pr_next,
  output logic                q_bit
);

  logic [2*MagWidth:0] shifted;

  // Arithmetic wraps at 2M+1 bits; the true result always fits, so the
  // dropped top bit of the shift is harmless.
  always_comb begin
    shifted = {pr[2*MagWidth-1:0], 1'b0};
    pr_next = pr[2*MagWidth] ? shifted + dv : shifted - dv;
    q_bit   = ~pr_next[2*MagWidth];
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative divider, one quotient bit per cycle, unsigned or sign-magnitude
// operands, with divide-by-zero detection and start/busy/done handshake.
module divider_seq
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SIGN_MAG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             start,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned M  = mag_width(WIDTH, SIGN_MAG);
  localparam int unsigned PW = 2 * M + 1;
  localparam int unsigned CW = $clog2(M);
  localparam logic [CW-1:0] CntLast = CW'(M - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pr_q, pr_d, step_pr, dv;
  logic [M-1:0]     ym_q, ym_d, qm_q, qm_d, qm_fin, rm_fin;
  logic [WIDTH-1:0] z_q, z_d, r_q, r_d, z_fix, r_fix;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic             step_q, accept, ym_zero;

  assign accept  = (state_q == StIdle) && start;
  assign ym_zero = (ym_q == '0);
  assign dv      = {1'b0, ym_q, {M{1'b0}}};

  div_step #(
    .MagWidth(M)
  ) u_step (
    .pr     (pr_q),
    .dv     (dv),
    .pr_next(step_pr),
    .q_bit  (step_q)
  );

  // Remainder correction only touches the upper half since dv's low half is zero;
  // on divide-by-zero the dividend is still untouched in the low half.
  assign qm_fin = ym_zero ? {M{1'b1}} : qm_q;
  assign rm_fin = ym_zero ? pr_q[M-1:0]
                          : pr_q[2*M-1:M] + (pr_q[2*M] ? ym_q : {M{1'b0}});

  if (SIGN_MAG == ModeSignMag) begin : g_sm
    logic xs_q, ys_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        xs_q <= 1'b0;
        ys_q <= 1'b0;
      end else if (accept) begin
        xs_q <= x[WIDTH-1];
        ys_q <= y[WIDTH-1];
      end
    end

    assign z_fix = {xs_q ^ ys_q, qm_fin};
    assign r_fix = {xs_q, rm_fin};
  end else begin : g_un
    assign z_fix = qm_fin;
    assign r_fix = rm_fin;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    ym_d    = ym_q;
    qm_d    = qm_q;
    z_d     = z_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          pr_d    = {{(M + 1){1'b0}}, x[M-1:0]};
          ym_d    = y[M-1:0];
          qm_d    = '0;
          cnt_d   = '0;
          state_d = (y[M-1:0] == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        pr_d  = step_pr;
        qm_d  = {qm_q[M-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        z_d     = z_fix;
        r_d     = r_fix;
        dbz_d   = ym_zero;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pr_q    <= '0;
      ym_q    <= '0;
      qm_q    <= '0;
      z_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      ym_q    <= ym_d;
      qm_q    <= qm_d;
      z_q     <= z_d;
      r_q     <= r_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign z    = z_q;
  assign r    = r_q;
  assign dbz  = dbz_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: six width/mode instances, directed cases then a random
// sweep checked against an arithmetic reference model.
module tb_divider_seq;

  localparam int NDut = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x_bus, y_bus;
  logic        start_v  [NDut];
  logic [31:0] z_all    [NDut];
  logic [31:0] r_all    [NDut];
  logic        busy_all [NDut];
  logic        done_all [NDut];
  logic        dbz_all  [NDut];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int unsigned cfg_w(int k);
    return (k == 1 || k == 5) ? 8 : (k == 3 || k == 4) ? 16 : 32;
  endfunction

  function automatic bit cfg_sm(int k);
    return (k == 1 || k == 2 || k == 4);
  endfunction

  for (genvar k = 0; k < NDut; k++) begin : g_dut
    localparam int unsigned W  = cfg_w(k);
    localparam bit          SM = cfg_sm(k);
    logic [W-1:0] zz, rr;
    logic         bb, dd, zf;

    divider_seq #(
      .WIDTH   (W),
      .SIGN_MAG(SM)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .x    (x_bus[W-1:0]),
      .y    (y_bus[W-1:0]),
      .start(start_v[k]),
      .z    (zz),
      .r    (rr),
      .busy (bb),
      .done (dd),
      .dbz  (zf)
    );

    assign z_all[k]    = 32'(zz);
    assign r_all[k]    = 32'(rr);
    assign busy_all[k] = bb;
    assign done_all[k] = dd;
    assign dbz_all[k]  = zf;
  end

  // Reference: plain integer division on the magnitudes, signs applied afterwards.
  task automatic model(input int k, input logic [31:0] xv, input logic [31:0] yv,
                       output logic [31:0] ez, output logic [31:0] er, output logic ed,
                       output int eb);
    int unsigned     w    = cfg_w(k);
    bit              sm   = cfg_sm(k);
    int unsigned     m    = sm ? w - 1 : w;
    longint unsigned mask = (64'd1 << m) - 1;
    longint unsigned xm   = 64'(xv) & mask;
    longint unsigned ym   = 64'(yv) & mask;
    longint unsigned qm, rm;
    logic            xs   = sm ? xv[w-1] : 1'b0;
    logic            ys   = sm ? yv[w-1] : 1'b0;
    if (ym == 0) begin
      qm = mask;
      rm = xm;
      ed = 1'b1;
      eb = 1;
    end else begin
      qm = xm / ym;
      rm = xm % ym;
      ed = 1'b0;
      eb = int'(m) + 1;
    end
    ez = 32'(qm);
    er = 32'(rm);
    if (sm) begin
      ez[w-1] = xs ^ ys;
      er[w-1] = xs;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int k, input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clk);
    x_bus      = xv;
    y_bus      = yv;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask

  // Returns at the negedge where done is seen (or after the cycle budget).
  task automatic wait_done(input int k, output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done_all[k]) seen = 1'b1;
      else if (busy_all[k]) busy_n++;
    end
  endtask

  task automatic check_res(input int k, input string tag, input logic [31:0] xv,
                           input logic [31:0] yv, input int busy_n, input bit seen);
    logic [31:0] ez, er;
    logic        ed;
    int          eb;
    model(k, xv, yv, ez, er, ed, eb);
    chk({tag, " done"}, 32'(seen), 32'd1);
    chk({tag, " z"}, z_all[k], ez);
    chk({tag, " r"}, r_all[k], er);
    chk({tag, " dbz"}, 32'(dbz_all[k]), 32'(ed));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(eb));
  endtask

  task automatic run_div(input int k, input logic [31:0] xv, input logic [31:0] yv,
                         input string tag);
    int busy_n;
    bit seen;
    start_op(k, xv, yv);
    wait_done(k, busy_n, seen);
    check_res(k, tag, xv, yv, busy_n, seen);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done_all[k]), 32'd0);
  endtask

  initial begin
    int          busy_n, busy_pre, dcount;
    bit          seen;
    int unsigned w, m;
    bit          sm;
    logic [31:0] mask, xm, ym, xv;

    for (int k = 0; k < NDut; k++) start_v[k] = 1'b0;
    x_bus = '0;
    y_bus = '0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDut; k++) begin
      chk("reset z", z_all[k], 32'd0);
      chk("reset r", r_all[k], 32'd0);
      chk("reset busy", 32'(busy_all[k]), 32'd0);
      chk("reset done", 32'(done_all[k]), 32'd0);
      chk("reset dbz", 32'(dbz_all[k]), 32'd0);
    end
    rst = 1'b0;

    run_div(0, 32'd100, 32'd7, "u32 100/7");
    chk("u32 100/7 z lit", z_all[0], 32'd14);
    chk("u32 100/7 r lit", r_all[0], 32'd2);
    run_div(1, 32'h85, 32'h02, "sm8 -5/+2");
    chk("sm8 -5/+2 z lit", z_all[1], 32'h82);
    chk("sm8 -5/+2 r lit", r_all[1], 32'h81);
    run_div(1, 32'h7F, 32'h81, "sm8 127/-1");
    chk("sm8 127/-1 z lit", z_all[1], 32'hFF);
    chk("sm8 127/-1 r lit", r_all[1], 32'h00);
    run_div(2, 32'h9, 32'h8000_0000, "sm32 dbz -0");
    chk("sm32 dbz z lit", z_all[2], 32'hFFFF_FFFF);
    chk("sm32 dbz r lit", r_all[2], 32'h9);

    // A second start while busy must not disturb the operation in flight.
    start_op(0, 32'd100, 32'd7);
    busy_pre = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy_all[0]) busy_pre++;
    end
    x_bus      = 32'd999;
    y_bus      = 32'd3;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(0, busy_n, seen);
    check_res(0, "ignored start", 32'd100, 32'd7, busy_pre + busy_n, seen);

    // Back-to-back: start raised in the done cycle.
    start_op(0, 32'd200, 32'd9);
    wait_done(0, busy_n, seen);
    check_res(0, "b2b first", 32'd200, 32'd9, busy_n, seen);
    x_bus      = 32'd77;
    y_bus      = 32'd5;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(0, busy_n, seen);
    check_res(0, "b2b second", 32'd77, 32'd5, busy_n, seen);

    run_div(0, 32'h1234, 32'd0, "u32 dbz");
    chk("u32 dbz z lit", z_all[0], 32'hFFFF_FFFF);

    // Reset mid-CALC, with start asserted in the same cycle.
    start_op(0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst        = 1'b1;
    start_v[0] = 1'b1;
    x_bus      = 32'd5;
    y_bus      = 32'd0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    start_v[0] = 1'b0;
    chk("rst z", z_all[0], 32'd0);
    chk("rst r", r_all[0], 32'd0);
    chk("rst busy", 32'(busy_all[0]), 32'd0);
    chk("rst done", 32'(done_all[0]), 32'd0);
    chk("rst dbz", 32'(dbz_all[0]), 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_all[0] || busy_all[0]) dcount++;
    end
    chk("rst no done", 32'(dcount), 32'd0);
    run_div(0, 32'd100, 32'd7, "after rst");

    for (int k = 0; k < NDut; k++) begin
      w    = cfg_w(k);
      sm   = cfg_sm(k);
      m    = sm ? w - 1 : w;
      mask = (m == 32) ? 32'hFFFF_FFFF : (32'd1 << m) - 32'd1;
      for (int i = 0; i < 40; i++) begin
        xm = $urandom & mask;
        ym = $urandom & mask;
        case (i % 6)
          0: begin
            if (ym == 0) ym = 32'd1;
            xm = xm % ym;
          end
          1: xm = ym;
          2: ym = 32'd1;
          3: begin
            xm = mask;
            if (i % 12 == 3) ym = mask;
          end
          4: ym = ym >> $urandom_range(0, m - 1);
          default: ;
        endcase
        xv = xm;
        if (sm) begin
          xv = xv | (32'($urandom_range(0, 1)) << (w - 1));
          ym = ym | (32'($urandom_range(0, 1)) << (w - 1));
        end
        run_div(k, xv, ym, $sformatf("rnd k%0d i%0d", k, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
